// File: rtl/npc_exec_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, optional load/store, commit.
// Latency: 4 cycles per ALU instruction, +2 for a load/store, plus any stall cycles.
// Backpressure: requests are held until the matching ready; responses wait until TIMEOUT.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   ifu_req_* / ifu_resp_*          fetch request handshake and response
//   inst_latch                      one-cycle pulse: decoder captures the fetched word
//   dec_mem_ren/wen, dec_halt       decode results, sampled in EXEC
//   lsu_req_* / lsu_resp_*          load/store request handshake and response
//   npc                             next PC from the EXU, sampled in COMMIT
//   pc, wb_en, instret              architectural PC, commit pulse, retired count
//   halt, fault, fault_cause        sticky terminal status
module npc_exec_ctrl #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = 32'h8000_0000,
    parameter int unsigned         TIMEOUT  = 255,
    parameter int unsigned         CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    output logic [ADDR_W-1:0] ifu_req_addr,
    input  logic              ifu_resp_valid,
    input  logic              ifu_resp_err,
    output logic              inst_latch,
    input  logic              dec_mem_ren,
    input  logic              dec_mem_wen,
    input  logic              dec_halt,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    output logic              lsu_req_we,
    input  logic              lsu_resp_valid,
    input  logic              lsu_resp_err,
    input  logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] pc,
    output logic              wb_en,
    output logic [CNT_W-1:0]  instret,
    output logic              halt,
    output logic              fault,
    output logic [2:0]        fault_cause
);

    typedef enum logic [3:0] {
        S_BOOT,
        S_IF_REQ,
        S_IF_WAIT,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_COMMIT,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam logic [2:0] C_IFETCH  = 3'd1;
    localparam logic [2:0] C_LSU     = 3'd2;
    localparam logic [2:0] C_TIMEOUT = 3'd3;
    localparam logic [2:0] C_RENWEN  = 3'd4;
    localparam logic [2:0] C_MISALGN = 3'd5;

    // Last counter value before expiry: a wait that has already spent
    // TIMEOUT-1 cycles faults on the next edge unless a response arrives.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t             state;
    logic [15:0]        wait_cnt;
    logic               mem_we;
    logic               halt_flag;
    logic               halt_q;
    logic               fault_q;
    logic [2:0]         cause_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   instret_q;

    logic               npc_ok;
    logic               wait_expired;
    logic [15:0]        wait_inc;

    assign npc_ok       = (npc[1:0] == 2'b00);
    assign wait_expired = (wait_cnt >= TO_LAST);
    assign wait_inc     = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    // All handshake outputs are pure decodes of the registered state.
    assign ifu_req_valid = (state == S_IF_REQ);
    assign ifu_req_addr  = pc_q;
    assign inst_latch    = (state == S_EXEC);
    assign lsu_req_valid = (state == S_MEM_REQ);
    assign lsu_req_we    = (state == S_MEM_REQ) && mem_we;
    // A misaligned npc turns COMMIT into a fault, so it must also suppress the write.
    assign wb_en         = (state == S_COMMIT) && npc_ok;
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign halt          = halt_q;
    assign fault         = fault_q;
    assign fault_cause   = cause_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_BOOT;
            wait_cnt  <= '0;
            mem_we    <= 1'b0;
            halt_flag <= 1'b0;
            halt_q    <= 1'b0;
            fault_q   <= 1'b0;
            cause_q   <= 3'd0;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            case (state)
                S_BOOT: state <= S_IF_REQ;

                S_IF_REQ: begin
                    if (ifu_req_ready) begin
                        state    <= S_IF_WAIT;
                        wait_cnt <= '0;
                    end
                end

                S_IF_WAIT: begin
                    // A response on the expiry cycle takes priority over the timeout.
                    if (ifu_resp_valid) begin
                        if (ifu_resp_err) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            cause_q <= C_IFETCH;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else if (wait_expired) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                        cause_q <= C_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end

                S_EXEC: begin
                    halt_flag <= dec_halt;
                    mem_we    <= dec_mem_wen;
                    if (dec_mem_ren && dec_mem_wen) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                        cause_q <= C_RENWEN;
                    end else if (dec_mem_ren || dec_mem_wen) begin
                        state <= S_MEM_REQ;
                    end else begin
                        state <= S_COMMIT;
                    end
                end

                S_MEM_REQ: begin
                    if (lsu_req_ready) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end

                S_MEM_WAIT: begin
                    if (lsu_resp_valid) begin
                        if (lsu_resp_err) begin
                            state   <= S_FAULT;
                            fault_q <= 1'b1;
                            cause_q <= C_LSU;
                        end else begin
                            state <= S_COMMIT;
                        end
                    end else if (wait_expired) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                        cause_q <= C_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end

                S_COMMIT: begin
                    if (!npc_ok) begin
                        state   <= S_FAULT;
                        fault_q <= 1'b1;
                        cause_q <= C_MISALGN;
                    end else begin
                        pc_q      <= npc;
                        instret_q <= instret_q + CNT_W'(1);
                        if (halt_flag) begin
                            state  <= S_HALTED;
                            halt_q <= 1'b1;
                        end else begin
                            state <= S_IF_REQ;
                        end
                    end
                end

                // Terminal states: nothing changes until reset, so the
                // recorded fault cause can never be overwritten.
                S_HALTED: state <= S_HALTED;
                S_FAULT:  state <= S_FAULT;

                default:  state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: doc/npc_exec_ctrl.md
Name: npc_exec_ctrl

Overview:
Parametrised multi-cycle instruction sequencer for the NPC core. It replaces the fixed fetch/done flag pair with an explicit FSM. The FSM drives valid/ready request handshakes to the instruction-fetch and load/store units and tolerates variable memory latency. It adds a bounded-wait timeout, error and misalignment faults, and a retired-instruction counter. It owns the architectural PC and sits between the fetch unit, decoder, LSU and register-file write enable.

Parameters:
ADDR_W, 32, PC/address width
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles waited for any memory response before fault (1..2^16-1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch unit accepts request
ifu_req_addr  out  ADDR_W  fetch address (= pc)
ifu_resp_valid  in  1  instruction returned
ifu_resp_err  in  1  fetch bus error, qualified by ifu_resp_valid
inst_latch  out  1  one-cycle pulse: decoder latches instruction
dec_mem_ren  in  1  decoded load, sampled in EXEC
dec_mem_wen  in  1  decoded store, sampled in EXEC
dec_halt  in  1  decoded ebreak/halt, sampled in EXEC
lsu_req_valid  out  1  LSU request valid
lsu_req_ready  in  1  LSU accepts request
lsu_req_we  out  1  1 = store, 0 = load; held while lsu_req_valid
lsu_resp_valid  in  1  load data / store ack
lsu_resp_err  in  1  LSU bus error, qualified by lsu_resp_valid
npc  in  ADDR_W  next PC from EXU, sampled in COMMIT
pc  out  ADDR_W  architectural PC
wb_en  out  1  one-cycle commit pulse gating GPR/CSR writes
instret  out  CNT_W  retired-instruction count
halt  out  1  sticky halted flag
fault  out  1  sticky fault flag
fault_cause  out  3  0 none, 1 ifetch err, 2 lsu err, 3 timeout, 4 ren&wen both set, 5 misaligned npc

Behaviour:
- Reset (rst low, asynchronous):
  - state = BOOT; pc = RESET_PC; instret = 0; halt = fault = 0; fault_cause = 0; wait counter = 0.
  - All request/pulse outputs are 0.
- States: BOOT, IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, COMMIT, HALTED, FAULT. All outputs are decoded from registered state.
- BOOT -> IF_REQ unconditionally, one cycle after reset release.
- IF_REQ:
  - ifu_req_valid = 1 and ifu_req_addr = pc, both held stable until ifu_req_ready.
  - On handshake -> IF_WAIT and the wait counter clears.
- IF_WAIT:
  - ifu_resp_valid & !ifu_resp_err -> inst_latch pulse, then -> EXEC.
  - ifu_resp_valid & ifu_resp_err -> FAULT, cause 1.
  - Counter reaches TIMEOUT -> FAULT, cause 3. A response in the same cycle as expiry wins.
- EXEC (exactly 1 cycle):
  - ren & wen -> FAULT, cause 4.
  - Else ren | wen -> MEM_REQ.
  - Else -> COMMIT.
  - dec_halt is captured into an internal flag here.
- MEM_REQ: lsu_req_valid = 1, lsu_req_we = captured wen. On handshake -> MEM_WAIT and the counter clears.
- MEM_WAIT: lsu_resp_valid -> COMMIT (err -> FAULT, cause 2). Timeout is handled as in IF_WAIT.
- COMMIT:
  - npc[1:0] != 0 -> FAULT, cause 5. pc is unchanged and there is no wb_en.
  - Otherwise:
    - wb_en = 1 for this cycle only; pc <= npc; instret <= instret + 1 (wraps modulo 2^CNT_W).
    - If halt flag captured -> HALTED, else -> IF_REQ.
- HALTED / FAULT:
  - Terminal until reset. halt (resp. fault) = 1; no requests are issued; pc frozen.
  - fault_cause is written once and never overwritten.
- Responses arriving outside the matching *_WAIT state are ignored.
- Ready asserted while valid = 0 has no effect.
- Minimum latency is 4 cycles per non-memory instruction (IF_REQ, IF_WAIT, EXEC, COMMIT) with same-cycle ready and next-cycle response. A load/store adds 2 cycles.
- Wait counter is 16 bits, saturating. It increments only in IF_WAIT/MEM_WAIT.
- Reset asserted mid-transaction aborts immediately. Any late response after release is ignored, since state is BOOT/IF_REQ.

Test Plan:
- Reset release, ifu ready=1, resp 1 cycle later, no mem, npc=pc+4, 3 instructions -> pc=0x8000_000C, instret=3, wb_en pulses exactly every 4 cycles, first ifu_req_addr=0x8000_0000.
- Load with lsu_req_ready low 3 cycles, resp 2 cycles after handshake -> lsu_req_valid held 4 cycles with we=0; wb_en once; instret=1.
- ifu_resp never arrives, TIMEOUT=8 -> fault=1, cause=3 exactly 8 cycles after handshake; pc unchanged; no further requests.
- dec_halt on 2nd instruction -> 2 wb_en pulses, halt=1, instret=2, pc=npc of 2nd instruction, ifu_req_valid stays 0.
- npc=0x8000_0006 at commit -> fault cause 5, wb_en not pulsed, pc keeps old value; separately ren=wen=1 -> cause 4.
- Assert rst during MEM_WAIT, inject lsu_resp_valid after release -> state restarts at BOOT, pc=RESET_PC, instret=0, response ignored.
